// File: rtl/mux4_rr_arbiter.sv
// Four-requester round-robin arbiter driving a 4:1 one-bit mux onto a shared resource.
// Define MUX4_ARB_TIMEOUT_EN to add the MAX_HOLD grant time limit.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [3:0] req_in,
  input  logic [3:0] data_in,
  output logic [3:0] gnt_out,
  output logic [1:0] sel_out,
  output logic       busy_out,
  output logic       y_out
);

  if (MAX_HOLD < 2 || MAX_HOLD > 15) begin : g_bad_hold
    $error("MAX_HOLD must be in 2..15");
  end

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;
  logic [2:0] pick;

`ifdef MUX4_ARB_TIMEOUT_EN
  logic [3:0] hold_q, hold_d;
`endif

  // Returns {found, index} of the first set mask bit in order base+1 .. base+4.
  function automatic logic [2:0] rr_pick(input logic [1:0] base, input logic [3:0] mask);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k + 1);
      if (mask[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    pick    = 3'b000;
`ifdef MUX4_ARB_TIMEOUT_EN
    hold_d  = hold_q;
`endif
    case (state_q)
      IDLE: pick = rr_pick(ptr_q, req_in);
      BUSY: begin
        if (!req_in[sel_q]) begin
          pick = rr_pick(sel_q, req_in);
          if (!pick[2]) state_d = IDLE;
        end
`ifdef MUX4_ARB_TIMEOUT_EN
        else if (hold_q == 4'(MAX_HOLD - 1)) begin
          // Time is up: hand over only if someone else is waiting, otherwise restart the count.
          pick = rr_pick(sel_q, req_in & ~(4'b0001 << sel_q));
          if (!pick[2]) hold_d = 4'd0;
        end else begin
          hold_d = hold_q + 4'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    if (pick[2]) begin
      state_d = BUSY;
      sel_d   = pick[1:0];
      ptr_d   = pick[1:0];
`ifdef MUX4_ARB_TIMEOUT_EN
      hold_d  = 4'd0;
`endif
    end
    gnt_d = (state_d == BUSY) ? (4'b0001 << sel_d) : 4'b0000;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      ptr_q   <= 2'b11;
      sel_q   <= 2'b00;
      gnt_q   <= 4'b0000;
`ifdef MUX4_ARB_TIMEOUT_EN
      hold_q  <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
`ifdef MUX4_ARB_TIMEOUT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign gnt_out  = gnt_q;
  assign sel_out  = sel_q;
  assign busy_out = (state_q == BUSY);
  // Gated by busy so an idle mux never leaks the last owner's data.
  assign y_out    = (state_q == BUSY) ? data_in[sel_q] : 1'b0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed vectors, literal checks, and a per-cycle
// comparison against a queue-free behavioural arbitration model.
module tb_mux4_rr_arbiter;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] data = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       y;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.MAX_HOLD(HOLD)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .req_in(req), .data_in(data),
    .gnt_out(gnt), .sel_out(sel), .busy_out(busy), .y_out(y)
  );

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the resource, where the search starts, cycles owned.
  logic     m_busy;
  int       m_owner, m_ptr, m_cnt;

  function automatic int first_in_order(input int from, input logic [3:0] mask);
    for (int k = 1; k <= 4; k++)
      if (mask[(from + k) % 4]) return (from + k) % 4;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int w;
    logic n_busy;
    int n_owner, n_ptr, n_cnt;
    if (!rst_n) begin
      m_busy <= 1'b0; m_owner <= 0; m_ptr <= 3; m_cnt <= 0;
    end else begin
      n_busy = m_busy; n_owner = m_owner; n_ptr = m_ptr; n_cnt = m_cnt;
      w = -1;
      if (!m_busy) w = first_in_order(m_ptr, req);
      else if (!req[m_owner]) begin
        w = first_in_order(m_owner, req);
        if (w < 0) n_busy = 1'b0;
      end else begin
`ifdef MUX4_ARB_TIMEOUT_EN
        if (m_cnt == HOLD - 1) begin
          w = first_in_order(m_owner, req & ~(4'b0001 << m_owner));
          if (w < 0) n_cnt = 0;
        end else n_cnt = m_cnt + 1;
`endif
      end
      if (w >= 0) begin
        n_busy = 1'b1; n_owner = w; n_ptr = w; n_cnt = 0;
      end
      m_busy <= n_busy; m_owner <= n_owner; m_ptr <= n_ptr; m_cnt <= n_cnt;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_gnt", gnt, m_busy ? (4'b0001 << m_owner) : 4'b0000);
      chk("model_sel", {2'b00, sel}, 4'(m_owner));
      chk("model_busy", {3'b000, busy}, {3'b000, m_busy});
      chk("model_y", {3'b000, y}, {3'b000, m_busy ? data[m_owner] : 1'b0});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    #1;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_sel", {2'b00, sel}, 4'b0000);
    chk("rst_busy", {3'b000, busy}, 4'b0000);
    chk("rst_y", {3'b000, y}, 4'b0000);
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  typedef struct { logic [3:0] r; logic [3:0] d; } vec_t;
  vec_t vecs[16];

  initial begin
    vecs = '{'{4'b0110, 4'b1010}, '{4'b0110, 4'b0101}, '{4'b0100, 4'b1111}, '{4'b1101, 4'b0001},
             '{4'b1101, 4'b1000}, '{4'b1100, 4'b0100}, '{4'b0000, 4'b1111}, '{4'b0000, 4'b1111},
             '{4'b1010, 4'b0010}, '{4'b1000, 4'b1000}, '{4'b0001, 4'b0111}, '{4'b0011, 4'b0011},
             '{4'b0010, 4'b0010}, '{4'b1111, 4'b1001}, '{4'b0111, 4'b1110}, '{4'b0000, 4'b0000}};

    repeat (2) @(posedge clk);
    #2;
    cmp_en = 1'b1;

    // Reset pointer is 3, so requester 0 wins first; dropping it hands over without a bubble.
    do_reset();
    req = 4'b0101;
    tick();
    chk("first_gnt", gnt, 4'b0001);
    chk("first_sel", {2'b00, sel}, 4'b0000);
    chk("first_busy", {3'b000, busy}, 4'b0001);
    req = 4'b0100;
    tick();
    chk("handover_gnt", gnt, 4'b0100);
    chk("handover_sel", {2'b00, sel}, 4'b0010);
    chk("handover_busy", {3'b000, busy}, 4'b0001);

    // Mux path follows data_in combinationally; idle forces y low.
    data = 4'b0100;
    #1 chk("y_owner_high", {3'b000, y}, 4'b0001);
    data = 4'b1011;
    #1 chk("y_owner_low", {3'b000, y}, 4'b0000);
    req = 4'b0000;
    tick();
    chk("idle_busy", {3'b000, busy}, 4'b0000);
    chk("idle_gnt", gnt, 4'b0000);
    chk("idle_y", {3'b000, y}, 4'b0000);
    chk("idle_sel_kept", {2'b00, sel}, 4'b0010);

    // Search wraps from pointer 3 to index 0 first, then 1.
    do_reset();
    req = 4'b1110;
    tick();
    chk("wrap_gnt", gnt, 4'b0010);

`ifdef MUX4_ARB_TIMEOUT_EN
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("rotate_sel", {2'b00, sel}, 4'((i / 4) % 4));
      chk("rotate_busy", {3'b000, busy}, 4'b0001);
    end
    do_reset();
    req = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("lone_hold_gnt", gnt, 4'b0010);
    end
`else
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("no_timeout_gnt", gnt, 4'b0001);
    end
    req = 4'b0010;
    tick();
    chk("no_timeout_drop_gnt", gnt, 4'b0010);
`endif

    // Reset mid-grant aborts immediately; arbitration restarts with latency 1.
    do_reset();
    req = 4'b1000;
    data = 4'b1000;
    tick();
    chk("own3_gnt", gnt, 4'b1000);
    chk("own3_y", {3'b000, y}, 4'b0001);
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt", gnt, 4'b0000);
    chk("midrst_sel", {2'b00, sel}, 4'b0000);
    chk("midrst_busy", {3'b000, busy}, 4'b0000);
    chk("midrst_y", {3'b000, y}, 4'b0000);
    tick();
    rst_n = 1'b1;
    tick();
    chk("postrst_gnt", gnt, 4'b1000);
    chk("postrst_sel", {2'b00, sel}, 4'b0011);

    // Directed table, checked against the model each cycle.
    do_reset();
    foreach (vecs[i]) begin
      req  = vecs[i].r;
      data = vecs[i].d;
      tick();
    end
    tick();

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "time limit");
  end
endmodule
